// File: rtl/turret_fire_controller.sv
// Turret pan/fire sequencer: steps the pan servo toward the tracked target once per frame,
// arms after a run of centered frames and fires one bounded pulse per whistle rising edge.
module turret_fire_controller #(
    parameter int CLK_HZ            = 25_000_000,
    parameter int PWM_PERIOD        = 500_000,
    parameter int SERVO_MIN         = 25_000,
    parameter int SERVO_MAX         = 50_000,
    parameter int SERVO_CENTER      = 37_500,
    parameter int STEP              = 250,
    parameter int ARM_FRAMES        = 3,
    parameter int FIRE_PULSE_CYCLES = 2_500_000,
    parameter int COOLDOWN_CYCLES   = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic        turn_left,
    input  logic        turn_right,
    input  logic        centered,
    input  logic        whistle_async,
    output logic        fire_out,
    output logic        servo_pwm,
    output logic [15:0] pan_pos,
    output logic        armed,
    output logic [2:0]  state_dbg
);

    localparam int PWM_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int FIRE_W = (FIRE_PULSE_CYCLES > 1) ? $clog2(FIRE_PULSE_CYCLES) : 1;
    localparam int CD_W   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int CTR_W  = $clog2(ARM_FRAMES + 1);

    localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
    localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(FIRE_PULSE_CYCLES - 1);
    localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CTR_W-1:0]  CTR_FULL  = CTR_W'(ARM_FRAMES);

    localparam logic signed [16:0] STEP_S    = 17'(STEP);
    localparam logic signed [16:0] PAN_MIN_S = 17'(SERVO_MIN);
    localparam logic signed [16:0] PAN_MAX_S = 17'(SERVO_MAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TRACK    = 3'd1,
        ARMED    = 3'd2,
        FIRING   = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    state_t             state;
    logic [FIRE_W-1:0]  fire_cnt;
    logic [CD_W-1:0]    cd_cnt;
    logic [CTR_W-1:0]   ctr_cnt;
    logic [CTR_W-1:0]   ctr_next;
    logic [CTR_W-1:0]   ctr_eff;

    logic               whistle_p0;
    logic               whistle_p1;
    logic               whistle_p2;
    logic               whistle_rise_p2;

    logic signed [16:0] pan_wide;
    logic signed [16:0] pan_sum;
    logic [15:0]        pan_next;

    logic [PWM_W-1:0]   pwm_cnt;
    logic [15:0]        width_q;

    // CLK_HZ is informational only; every timing parameter is already expressed in clk cycles.
    logic [31:0]        unused_clk_hz;
    assign unused_clk_hz = 32'(CLK_HZ);

    function automatic logic [15:0] sat_pan(input logic signed [16:0] val);
        if (val < PAN_MIN_S) begin
            return 16'(SERVO_MIN);
        end else if (val > PAN_MAX_S) begin
            return 16'(SERVO_MAX);
        end else begin
            return val[15:0];
        end
    endfunction

    // Stage p0/p1: two-flop synchronizer; stage p2: registered rising-edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            whistle_p0      <= 1'b0;
            whistle_p1      <= 1'b0;
            whistle_p2      <= 1'b0;
            whistle_rise_p2 <= 1'b0;
        end else begin
            whistle_p0      <= whistle_async;
            whistle_p1      <= whistle_p0;
            whistle_p2      <= whistle_p1;
            whistle_rise_p2 <= whistle_p1 & ~whistle_p2;
        end
    end

    always_comb begin
        pan_wide = signed'({1'b0, pan_pos});
        pan_sum  = pan_wide;
        if (turn_left && !turn_right) begin
            pan_sum = pan_wide - STEP_S;
        end else if (turn_right && !turn_left) begin
            pan_sum = pan_wide + STEP_S;
        end
        pan_next = sat_pan(pan_sum);
    end

    // ctr_eff is what ctr_cnt becomes this edge, so arming lands on the qualifying tick itself.
    always_comb begin
        ctr_next = '0;
        if (centered && !turn_left && !turn_right) begin
            ctr_next = (ctr_cnt == CTR_FULL) ? ctr_cnt : ctr_cnt + 1'b1;
        end
        ctr_eff = frame_tick ? ctr_next : ctr_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fire_out <= 1'b0;
            armed    <= 1'b0;
            fire_cnt <= '0;
            cd_cnt   <= '0;
            ctr_cnt  <= '0;
            pan_pos  <= 16'(SERVO_CENTER);
        end else if (!enable) begin
            state    <= IDLE;
            fire_out <= 1'b0;
            armed    <= 1'b0;
            fire_cnt <= '0;
            cd_cnt   <= '0;
            ctr_cnt  <= '0;
        end else begin
            if (frame_tick) begin
                ctr_cnt <= ctr_next;
            end
            if (frame_tick && (state == TRACK || state == ARMED)) begin
                pan_pos <= pan_next;
            end
            case (state)
                IDLE: begin
                    // A fresh run of centered frames is required after every re-enable.
                    ctr_cnt <= '0;
                    state   <= TRACK;
                end
                TRACK: begin
                    if (ctr_eff == CTR_FULL) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                end
                ARMED: begin
                    if (whistle_rise_p2) begin
                        state    <= FIRING;
                        armed    <= 1'b0;
                        fire_out <= 1'b1;
                        fire_cnt <= '0;
                    end else if (frame_tick && !centered) begin
                        state   <= TRACK;
                        armed   <= 1'b0;
                        ctr_cnt <= '0;
                    end
                end
                FIRING: begin
                    if (fire_cnt == FIRE_LAST) begin
                        state    <= COOLDOWN;
                        fire_out <= 1'b0;
                        cd_cnt   <= '0;
                    end else begin
                        fire_cnt <= fire_cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == CD_LAST) begin
                        state   <= TRACK;
                        ctr_cnt <= '0;
                    end else begin
                        cd_cnt <= cd_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    fire_out <= 1'b0;
                    armed    <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

    // Width is latched only at the frame boundary so a pan change never truncates a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            width_q   <= 16'(SERVO_CENTER);
            servo_pwm <= 1'b0;
        end else begin
            servo_pwm <= (32'(pwm_cnt) < 32'(width_q));
            if (pwm_cnt == PWM_LAST) begin
                pwm_cnt <= '0;
                width_q <= pan_pos;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_turret_fire_controller.sv
// Directed bench for turret_fire_controller with small sim timing parameters.
module tb_turret_fire_controller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        frame_tick;
    logic        turn_left;
    logic        turn_right;
    logic        centered;
    logic        whistle_async;
    logic        fire_out;
    logic        servo_pwm;
    logic [15:0] pan_pos;
    logic        armed;
    logic [2:0]  state_dbg;

    int n_checks;
    int n_pass;
    int highs;

    turret_fire_controller #(
        .CLK_HZ           (25_000_000),
        .PWM_PERIOD       (100),
        .SERVO_MIN        (10),
        .SERVO_MAX        (20),
        .SERVO_CENTER     (15),
        .STEP             (2),
        .ARM_FRAMES       (3),
        .FIRE_PULSE_CYCLES(8),
        .COOLDOWN_CYCLES  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .centered     (centered),
        .whistle_async(whistle_async),
        .fire_out     (fire_out),
        .servo_pwm    (servo_pwm),
        .pan_pos      (pan_pos),
        .armed        (armed),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic l, input logic r, input logic c);
        turn_left  = l;
        turn_right = r;
        centered   = c;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic wait_rise();
        logic prev;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            prev = servo_pwm;
            step(1);
            if (!prev && servo_pwm) seen = 1'b1;
        end
        check_eq("pwm_rise_seen", int'(seen), 1);
    endtask

    // Starts on the first high sample of a PWM frame and ends on the first sample of the next.
    task automatic measure_frame(input bit inject, output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (servo_pwm) cnt++;
            if (inject && (i == 2 || i == 3)) begin
                turn_right = 1'b1;
                frame_tick = 1'b1;
            end else begin
                frame_tick = 1'b0;
            end
            step(1);
        end
        frame_tick = 1'b0;
        turn_right = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        enable        = 1'b0;
        frame_tick    = 1'b0;
        turn_left     = 1'b0;
        turn_right    = 1'b0;
        centered      = 1'b0;
        whistle_async = 1'b0;
        step(2);
        check_eq("rst_state", int'(state_dbg), 0);
        check_eq("rst_pan", int'(pan_pos), 15);
        check_eq("rst_fire", int'(fire_out), 0);
        check_eq("rst_pwm", int'(servo_pwm), 0);
        check_eq("rst_armed", int'(armed), 0);

        // Pan stepping with saturation and PWM width
        rst_n  = 1'b1;
        enable = 1'b1;
        step(1);
        check_eq("idle_to_track", int'(state_dbg), 1);
        frame(1'b0, 1'b1, 1'b0);
        check_eq("pan_step1", int'(pan_pos), 17);
        frame(1'b0, 1'b1, 1'b0);
        check_eq("pan_step2", int'(pan_pos), 19);
        frame(1'b0, 1'b1, 1'b0);
        check_eq("pan_sat_max", int'(pan_pos), 20);
        wait_rise();
        measure_frame(1'b0, highs);
        measure_frame(1'b0, highs);
        check_eq("pwm_width_20", highs, 20);

        // Arming, fire pulse length, cooldown
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        check_eq("armed_after_2", int'(armed), 0);
        frame(1'b0, 1'b0, 1'b1);
        check_eq("armed_after_3", int'(armed), 1);
        check_eq("state_armed", int'(state_dbg), 2);
        whistle_async = 1'b1;
        step(3);
        check_eq("fire_latency_n2", int'(fire_out), 0);
        step(1);
        check_eq("fire_latency_n3", int'(fire_out), 1);
        check_eq("state_firing", int'(state_dbg), 3);
        highs = 1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (fire_out) highs++;
        end
        check_eq("fire_len", highs, 8);
        step(1);
        check_eq("fire_end", int'(fire_out), 0);
        check_eq("state_cooldown", int'(state_dbg), 4);
        step(15);
        check_eq("cooldown_last", int'(state_dbg), 4);
        step(1);
        check_eq("cooldown_done", int'(state_dbg), 1);

        // Whistle held high through cooldown and re-arm: no second shot
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        step(5);
        check_eq("held_no_refire", int'(fire_out), 0);
        check_eq("held_still_armed", int'(state_dbg), 2);
        whistle_async = 1'b0;

        // Disarm on off-centre frame, then whistle in TRACK is ignored
        frame(1'b0, 1'b0, 1'b0);
        check_eq("disarm_track", int'(state_dbg), 1);
        step(2);
        whistle_async = 1'b1;
        step(3);
        whistle_async = 1'b0;
        step(4);
        check_eq("track_whistle_fire", int'(fire_out), 0);
        check_eq("track_whistle_state", int'(state_dbg), 1);

        // Whistle edge and off-centre frame on the same cycle: whistle wins
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        check_eq("rearm", int'(armed), 1);
        whistle_async = 1'b1;
        step(3);
        centered   = 1'b0;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check_eq("race_state", int'(state_dbg), 3);
        check_eq("race_fire", int'(fire_out), 1);
        whistle_async = 1'b0;
        step(9);
        check_eq("cd_entered", int'(state_dbg), 4);
        whistle_async = 1'b1;
        step(2);
        whistle_async = 1'b0;
        step(3);
        check_eq("cd_whistle_fire", int'(fire_out), 0);
        check_eq("cd_whistle_state", int'(state_dbg), 4);
        step(10);
        check_eq("cd_exit", int'(state_dbg), 1);

        // enable=0 aborts FIRING at cycle 4, pan held
        frame(1'b1, 1'b0, 1'b0);
        check_eq("pan_left", int'(pan_pos), 18);
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        whistle_async = 1'b1;
        step(4);
        whistle_async = 1'b0;
        check_eq("abort_firing", int'(state_dbg), 3);
        step(3);
        enable = 1'b0;
        step(1);
        check_eq("abort_fire", int'(fire_out), 0);
        check_eq("abort_state", int'(state_dbg), 0);
        check_eq("abort_pan", int'(pan_pos), 18);
        enable = 1'b1;
        step(1);
        check_eq("reenable", int'(state_dbg), 1);

        // Reset mid-FIRING
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        check_eq("arm_before_rst", int'(armed), 1);
        whistle_async = 1'b1;
        step(4);
        whistle_async = 1'b0;
        step(2);
        check_eq("firing_before_rst", int'(fire_out), 1);
        rst_n = 1'b0;
        step(1);
        check_eq("rst_fire_mid", int'(fire_out), 0);
        check_eq("rst_pan_mid", int'(pan_pos), 15);
        check_eq("rst_state_mid", int'(state_dbg), 0);
        rst_n    = 1'b1;
        centered = 1'b0;
        step(1);

        // Pan change mid PWM frame does not alter that frame's pulse
        wait_rise();
        measure_frame(1'b1, highs);
        check_eq("pwm_frame_unchanged", highs, 15);
        check_eq("pan_after_inject", int'(pan_pos), 19);
        measure_frame(1'b0, highs);
        check_eq("pwm_next_frame", highs, 19);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
